// File: rtl/cache_line_arbiter_if.sv
// Bundles both cache line-miss ports and the shared 64-bit burst memory port.
// Latency: none; this file only declares wires.
// Backpressure: memory stalls via mem_resp; caches hold their request until resp.
interface cache_line_arbiter_if;
  // I-cache line-miss port
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  // D-cache line-miss port
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  // Shared burst memory port
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  // Arbiter side: consumes cache requests and memory beats, drives the rest.
  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Environment side: the two caches plus physical memory.
  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one 64-bit, 4-beat burst memory port.
// Latency: grant at the first IDLE edge, 4 beats, then a 1-cycle resp (6 cycles with no stalls).
// Backpressure: mem_resp=0 freezes the burst; a losing requester waits for the next IDLE cycle.
module cache_line_arbiter (
  input  logic                  clk,
  input  logic                  rst,
  cache_line_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state;
  logic [1:0]   beat;       // index of the beat currently on the memory port
  logic [255:0] line_buf;   // writeback source / fill destination
  logic [31:0]  addr_q;     // line-aligned address of the active burst
  logic         last_d;     // 1 when the D-cache won the most recent grant
  logic         gnt_d;      // side owning the current transfer (1 = D)
  logic         mem_read_q;
  logic         mem_write_q;
  logic         i_resp_q;
  logic         d_resp_q;

  logic i_req;
  logic d_req;
  logic pick_d;

  // Round-robin on a tie: the side not granted last time wins.
  assign i_req  = bus.i_read;
  assign d_req  = bus.d_read | bus.d_write;
  assign pick_d = d_req & (~i_req | ~last_d);

  // Main FSM: grant, burst sequencing, line buffer and registered port controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      beat        <= 2'd0;
      line_buf    <= '0;
      addr_q      <= '0;
      last_d      <= 1'b1;
      gnt_d       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          if (i_req || d_req) begin
            beat   <= 2'd0;
            last_d <= pick_d;
            gnt_d  <= pick_d;
            if (pick_d) begin
              addr_q <= {bus.d_addr[31:5], 5'b0};
              // A write wins over a simultaneous read from the same cache.
              if (bus.d_write) begin
                line_buf    <= bus.d_wdata;
                mem_write_q <= 1'b1;
                state       <= D_WR;
              end else begin
                mem_read_q <= 1'b1;
                state      <= D_RD;
              end
            end else begin
              addr_q     <= {bus.i_addr[31:5], 5'b0};
              mem_read_q <= 1'b1;
              state      <= I_RD;
            end
          end
        end

        I_RD, D_RD: begin
          if (bus.mem_resp) begin
            line_buf[{beat, 6'd0} +: 64] <= bus.mem_rdata;
            if (beat == 2'd3) begin
              beat       <= 2'd0;
              mem_read_q <= 1'b0;
              i_resp_q   <= ~gnt_d;
              d_resp_q   <= gnt_d;
              state      <= DONE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end

        D_WR: begin
          if (bus.mem_resp) begin
            if (beat == 2'd3) begin
              beat        <= 2'd0;
              mem_write_q <= 1'b0;
              i_resp_q    <= 1'b0;
              d_resp_q    <= 1'b1;
              state       <= DONE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end

        DONE: begin
          // Resp has been visible for exactly this cycle; requester drops next.
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          i_resp_q    <= 1'b0;
          d_resp_q    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Every output is a pure decode of registered state; no input-to-output path.
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_write_q ? line_buf[{beat, 6'd0} +: 64] : 64'd0;
  assign bus.i_resp    = i_resp_q;
  assign bus.d_resp    = d_resp_q;
  assign bus.i_rdata   = line_buf;
  assign bus.d_rdata   = line_buf;

endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Arbitrates the instruction cache and data cache for a single shared 64-bit burst memory port. Each 256-bit cache line is moved as four 64-bit beats. A registered line buffer serialises writebacks and assembles fills. The block sits between the two caches' line-miss interfaces and physical memory, and supplies the 256-bit line that each cache writes into its data array.

## Interface
- No parameters. Line = 256 bits, beat = 64 bits, burst = 4 beats.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_read  in  1  I-cache line-read request; held until i_resp.
- i_addr  in  32  I-cache line address; bits [4:0] ignored.
- i_rdata  out  256  fill line; valid only while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_read  in  1  D-cache line-read request; held until d_resp.
- d_write  in  1  D-cache writeback request; held until d_resp.
- d_addr  in  32  D-cache line address; bits [4:0] ignored.
- d_wdata  in  256  writeback line; sampled at grant.
- d_rdata  out  256  fill line; valid only while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- mem_read  out  1  burst read active.
- mem_write  out  1  burst write active.
- mem_addr  out  32  line-aligned burst address, {addr[31:5], 5'b0}.
- mem_wdata  out  64  current write beat.
- mem_rdata  in  64  current read beat; valid when mem_resp=1.
- mem_resp  in  1  beat accepted or returned this cycle.

## Operation
- States:
  - IDLE
  - I_RD
  - D_RD
  - D_WR
  - DONE
- IDLE, arbitration:
  - Requests pending: i = i_read; d = d_read | d_write.
  - Only one side pending: grant it.
  - Both pending: grant the side not granted last. The last_grant flop resets to D, so I wins the first tie.
  - d_write and d_read both high: treated as a write (d_write has precedence).
- At grant:
  - Register the line address.
  - For D_WR, load d_wdata into the line buffer.
  - Clear beat counter to 0.
  - Update last_grant.
  - Go to I_RD, D_RD or D_WR.
- I_RD / D_RD:
  - mem_read=1.
  - On each mem_resp: line_buf[64*k +: 64] <= mem_rdata; k++.
  - On beat 3: go to DONE.
- D_WR:
  - mem_write=1; mem_wdata = line_buf[64*k +: 64].
  - k++ on each mem_resp; go to DONE on beat 3.
- mem_resp=0 stalls the burst. Counter, address and buffer hold, and mem_read/mem_write stay asserted.
- DONE:
  - mem_read=mem_write=0.
  - Assert exactly one of i_resp/d_resp (the granted side) for one cycle.
  - i_rdata and d_rdata are both driven continuously from line_buf.
  - Next state is IDLE.
- Requesters must deassert their request in the cycle after resp. The arbiter does not filter stale requests.
- mem_resp outside I_RD/D_RD/D_WR is ignored.
- Beat counter is 2 bits, 0..3; it never wraps mid-burst because the FSM leaves on beat 3.

## Timing
- All outputs decode from registered state and registered buffers; there is no combinational path from any input to any output.
- Reset (rst=0): immediate, asynchronous.
  - State IDLE; counter 0; line_buf 0; address 0; last_grant=D.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- Reset mid-burst: the memory port drops in the same cycle, and no resp is issued for the aborted transfer.
- Latency:
  - Request sampled in IDLE at edge 0 → mem_read/mem_write high from edge 0.
  - With mem_resp=1 every cycle, beats complete at edges 1–4 → DONE after edge 4 → resp high for cycle 5.
  - Total 6 cycles from request to resp, plus memory stall cycles.
- Back-to-back: after DONE, IDLE lasts at least 1 cycle before the next grant. Minimum spacing between bursts is 2 idle memory cycles.
- A request arriving while another burst is in progress waits. It is granted in the first IDLE cycle.

## Test plan
- I-cache read: i_read, i_addr=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with mem_resp every cycle. Required:
  - mem_addr=0x0000_1220.
  - i_resp for exactly one cycle, 6 cycles after the request.
  - i_rdata = {0x44..,0x33..,0x22..,0x11..}.
  - d_resp stays 0.
- D-cache writeback: d_write, d_addr=0x8000_00FF, d_wdata=256'h0123…CDEF. Required:
  - mem_addr=0x8000_00E0.
  - mem_wdata sequence = d_wdata[63:0], [127:64], [191:128], [255:192].
  - Then one d_resp pulse.
- Tie arbitration: i_read and d_read asserted together, three times in succession. Required:
  - Grant order I, D, I.
  - Each requester receives its own line.
- Stall: during a D read, hold mem_resp=0 for 5 cycles between beats 1 and 2. Required:
  - mem_read stays high and mem_addr is stable.
  - Beat 2 is captured correctly.
  - resp is delayed by exactly 5 cycles.
- Reset mid-burst: assert rst=0 after beat 2 of an I read. Required:
  - mem_read=0 and all outputs 0 immediately.
  - No i_resp.
  - After release, a new d_read completes normally and the first tie afterwards goes to I.
- Simultaneous d_read and d_write: with d_wdata=all 0xAA, required mem_write burst with 0xAAAA_AAAA_AAAA_AAAA on every beat, and mem_read=0 throughout.
